// File: rtl/aludec_mdu_ctrl_pkg.sv
// Shared encodings for the decode-to-execute control block: opcodes, functs,
// ALU control words, MDU class codes and sequencer states.
package aludec_mdu_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type functs
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
  localparam logic [5:0] FnSllv  = 6'b000100;
  localparam logic [5:0] FnSrlv  = 6'b000110;
  localparam logic [5:0] FnSrav  = 6'b000111;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;

  // ALU control words; NOP is zero so a cleared register is a bubble
  typedef enum logic [4:0] {
    AluNop  = 5'd0,
    AluAdd  = 5'd1,
    AluAddu = 5'd2,
    AluSub  = 5'd3,
    AluSubu = 5'd4,
    AluAnd  = 5'd5,
    AluOr   = 5'd6,
    AluXor  = 5'd7,
    AluNor  = 5'd8,
    AluSlt  = 5'd9,
    AluSltu = 5'd10,
    AluSll  = 5'd11,
    AluSrl  = 5'd12,
    AluSra  = 5'd13,
    AluLui  = 5'd14
  } alu_ctrl_e;

  // MDU class of an instruction; MdcHilo covers MFHI/MFLO/MTHI/MTLO
  typedef enum logic [2:0] {
    MdcNone  = 3'd0,
    MdcMult  = 3'd1,
    MdcMultu = 3'd2,
    MdcDiv   = 3'd3,
    MdcDivu  = 3'd4,
    MdcHilo  = 3'd5
  } mdu_cls_e;

  // Operation code sent to the MDU datapath
  typedef enum logic [1:0] {
    MduMult  = 2'b00,
    MduMultu = 2'b01,
    MduDiv   = 2'b10,
    MduDivu  = 2'b11
  } mdu_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mdu_state_e;

  // True for classes that actually launch an MDU operation
  function automatic logic cls_is_muldiv(mdu_cls_e cls);
    return (cls == MdcMult) || (cls == MdcMultu) || (cls == MdcDiv) || (cls == MdcDivu);
  endfunction

  // True for the divide classes, which use the longer latency
  function automatic logic cls_is_div(mdu_cls_e cls);
    return (cls == MdcDiv) || (cls == MdcDivu);
  endfunction

  function automatic mdu_op_e cls_to_op(mdu_cls_e cls);
    unique case (cls)
      MdcMultu: return MduMultu;
      MdcDiv:   return MduDiv;
      MdcDivu:  return MduDivu;
      default:  return MduMult;
    endcase
  endfunction

endpackage

// File: rtl/aludec_mdu_ctrl_if.sv
// D-stage inputs and E-stage/MDU outputs of the decode-to-execute control block.
interface aludec_mdu_ctrl_if #(
  parameter int unsigned CTRL_W = 5
);
  logic [5:0]        op;
  logic [5:0]        funct;
  logic              valid_d;
  logic              stall_i;
  logic              flush_i;
  logic [CTRL_W-1:0] aluctrl_e;
  logic              ri_e;
  logic              mdu_start;
  logic [1:0]        mdu_op;
  logic              mdu_busy;
  logic              hilo_we;
  logic              stall_o;

  // Controller / hazard-unit side
  modport master (
    output op, funct, valid_d, stall_i, flush_i,
    input  aluctrl_e, ri_e, mdu_start, mdu_op, mdu_busy, hilo_we, stall_o
  );

  // Control block side
  modport slave (
    input  op, funct, valid_d, stall_i, flush_i,
    output aluctrl_e, ri_e, mdu_start, mdu_op, mdu_busy, hilo_we, stall_o
  );
endinterface

// File: rtl/aludec_mdu_ctrl_mdu_seq.sv
// Multiply/divide sequencer: IDLE/RUN/DONE FSM, latency counter and a started
// flag so an op held in E by a stall is launched only once.
module mdu_seq
  import aludec_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     i_e_valid,
  input  mdu_cls_e i_e_cls,
  input  logic     i_de_load,   // D->E register loads this cycle
  output logic     o_start,
  output logic [1:0] o_op,
  output logic     o_busy,
  output logic     o_hilo_we
);

  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  mdu_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_started, w_started_d;
  logic [CntW-1:0] w_load;

  // Next state, counter and start pulse
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_load    = cls_is_div(i_e_cls) ? DivLoad : MulLoad;
    o_start   = i_e_valid && cls_is_muldiv(i_e_cls) && !r_started &&
                ((r_state == StIdle) || (r_state == StDone));

    unique case (r_state)
      StIdle: ;
      StRun: begin
        w_cnt_d = r_cnt - 1'b1;
        // Counter reaching zero after this decrement ends RUN
        if (r_cnt <= CntW'(1)) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // A start overrides the DONE->IDLE return, giving back-to-back ops
    if (o_start) begin
      w_cnt_d   = w_load;
      w_state_d = (w_load == '0) ? StDone : StRun;
    end

    // A new instruction entering E may start again; otherwise remember the launch
    w_started_d = i_de_load ? 1'b0 : (r_started | o_start);

    o_op      = o_start ? cls_to_op(i_e_cls) : MduMult;
    o_busy    = (r_state == StRun);
    o_hilo_we = (r_state == StDone);
  end

  // State, counter and started flag; only reset aborts a running op
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_started <= w_started_d;
    end
  end

endmodule

// File: rtl/aludec_mdu_ctrl.sv
// Decode-to-execute control: ALU decode, D->E pipeline register and MDU
// sequencing with a HI/LO hazard stall towards the D stage.
module aludec_mdu_ctrl
  import aludec_mdu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned MUL_CYCLES = 2,   // >= 1
  parameter int unsigned DIV_CYCLES = 32   // >= 1 and >= MUL_CYCLES
) (
  input logic              clk,
  input logic              resetn,
  aludec_mdu_ctrl_if.slave bus
);

  alu_ctrl_e         w_dec_ctrl;
  logic              w_dec_ri;
  mdu_cls_e          w_dec_cls;

  logic [CTRL_W-1:0] r_ctrl_e;
  logic              r_ri_e;
  logic              r_valid_e;
  mdu_cls_e          r_cls_e;

  logic              w_de_load;
  logic              w_start;
  logic [1:0]        w_op;
  logic              w_busy;
  logic              w_hilo_we;

  // D-stage decode of op/funct into ALU control, RI flag and MDU class
  always_comb begin
    w_dec_ctrl = AluNop;
    w_dec_ri   = 1'b0;
    w_dec_cls  = MdcNone;
    case (bus.op)
      OpRtype: begin
        case (bus.funct)
          FnAdd:           w_dec_ctrl = AluAdd;
          FnAddu:          w_dec_ctrl = AluAddu;
          FnSub:           w_dec_ctrl = AluSub;
          FnSubu:          w_dec_ctrl = AluSubu;
          FnAnd:           w_dec_ctrl = AluAnd;
          FnOr:            w_dec_ctrl = AluOr;
          FnXor:           w_dec_ctrl = AluXor;
          FnNor:           w_dec_ctrl = AluNor;
          FnSlt:           w_dec_ctrl = AluSlt;
          FnSltu:          w_dec_ctrl = AluSltu;
          FnSll, FnSllv:   w_dec_ctrl = AluSll;
          FnSrl, FnSrlv:   w_dec_ctrl = AluSrl;
          FnSra, FnSrav:   w_dec_ctrl = AluSra;
          FnMult:          w_dec_cls  = MdcMult;
          FnMultu:         w_dec_cls  = MdcMultu;
          FnDiv:           w_dec_cls  = MdcDiv;
          FnDivu:          w_dec_cls  = MdcDivu;
          FnMfhi, FnMflo,
          FnMthi, FnMtlo:  w_dec_cls  = MdcHilo;
          default:         w_dec_ri   = 1'b1;
        endcase
      end
      OpAddi:                   w_dec_ctrl = AluAdd;
      OpAddiu:                  w_dec_ctrl = AluAddu;
      OpSlti:                   w_dec_ctrl = AluSlt;
      OpSltiu:                  w_dec_ctrl = AluSltu;
      OpAndi:                   w_dec_ctrl = AluAnd;
      OpOri:                    w_dec_ctrl = AluOr;
      OpXori:                   w_dec_ctrl = AluXor;
      OpLui:                    w_dec_ctrl = AluLui;
      OpLw, OpSw, OpJ, OpJal:   w_dec_ctrl = AluAdd;
      OpBeq, OpBne:             w_dec_ctrl = AluSub;
      default:                  w_dec_ri   = 1'b1;
    endcase
  end

  // D->E register: flush beats stall, a stall holds, otherwise load (bubble if !valid_d)
  always_ff @(posedge clk) begin
    if (!resetn || bus.flush_i) begin
      r_ctrl_e  <= CTRL_W'(AluNop);
      r_ri_e    <= 1'b0;
      r_valid_e <= 1'b0;
      r_cls_e   <= MdcNone;
    end else if (!bus.stall_i) begin
      if (bus.valid_d) begin
        r_ctrl_e  <= CTRL_W'(w_dec_ctrl);
        r_ri_e    <= w_dec_ri;
        r_valid_e <= 1'b1;
        r_cls_e   <= w_dec_cls;
      end else begin
        r_ctrl_e  <= CTRL_W'(AluNop);
        r_ri_e    <= 1'b0;
        r_valid_e <= 1'b0;
        r_cls_e   <= MdcNone;
      end
    end
  end

  assign w_de_load = bus.flush_i | ~bus.stall_i;

  mdu_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_seq (
    .clk        (clk),
    .resetn     (resetn),
    .i_e_valid  (r_valid_e),
    .i_e_cls    (r_cls_e),
    .i_de_load  (w_de_load),
    .o_start    (w_start),
    .o_op       (w_op),
    .o_busy     (w_busy),
    .o_hilo_we  (w_hilo_we)
  );

  // Outputs; the HI/LO stall is purely combinational on the D inputs. DONE is
  // excluded because HI/LO is written on that edge, before a D op reaches E.
  always_comb begin
    bus.aluctrl_e = r_ctrl_e;
    bus.ri_e      = r_ri_e;
    bus.mdu_start = w_start;
    bus.mdu_op    = w_op;
    bus.mdu_busy  = w_busy;
    bus.hilo_we   = w_hilo_we;
    bus.stall_o   = bus.valid_d && (w_dec_cls != MdcNone) && (w_busy || w_start);
  end

endmodule

// File: tb/tb_aludec_mdu_ctrl.sv
// Scoreboard bench for aludec_mdu_ctrl: expectations are queued with a target
// cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_aludec_mdu_ctrl;
  import aludec_mdu_ctrl_pkg::*;

  localparam int SigAlu   = 0;
  localparam int SigRi    = 1;
  localparam int SigStart = 2;
  localparam int SigOp    = 3;
  localparam int SigBusy  = 4;
  localparam int SigWe    = 5;
  localparam int SigStall = 6;

  typedef struct {
    int          cyc;
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       valid;
    alu_ctrl_e  ctrl;
    logic       ri;
  } dec_vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tb_flush = 1'b0;
  logic tb_hz = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  aludec_mdu_ctrl_if #(.CTRL_W(5)) bus ();

  aludec_mdu_ctrl #(
    .CTRL_W     (5),
    .MUL_CYCLES (2),
    .DIV_CYCLES (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Hazard unit model: a D stall inserts a bubble into E when enabled
  assign bus.flush_i = tb_flush | (tb_hz & bus.stall_o);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int sig);
    case (sig)
      SigAlu:   return 32'(bus.aluctrl_e);
      SigRi:    return 32'(bus.ri_e);
      SigStart: return 32'(bus.mdu_start);
      SigOp:    return 32'(bus.mdu_op);
      SigBusy:  return 32'(bus.mdu_busy);
      SigWe:    return 32'(bus.hilo_we);
      default:  return 32'(bus.stall_o);
    endcase
  endfunction

  // Scoreboard: compare every expectation due in this cycle
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].cyc <= cyc) begin
        if (sb_q[i].cyc < cyc) check({sb_q[i].tag, "_missed"}, 32'(sb_q[i].cyc), 32'(cyc));
        else                   check(sb_q[i].tag, peek(sb_q[i].sig), sb_q[i].val);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc + d;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic valid);
    bus.op      = op;
    bus.funct   = funct;
    bus.valid_d = valid;
  endtask

  task automatic expect_reset(input int d, input string tag);
    expect_at(d, {tag, "_alu"},   SigAlu,   32'(AluNop));
    expect_at(d, {tag, "_ri"},    SigRi,    0);
    expect_at(d, {tag, "_start"}, SigStart, 0);
    expect_at(d, {tag, "_op"},    SigOp,    0);
    expect_at(d, {tag, "_busy"},  SigBusy,  0);
    expect_at(d, {tag, "_we"},    SigWe,    0);
    expect_at(d, {tag, "_stall"}, SigStall, 0);
  endtask

  dec_vec_t dec_tbl[$];

  initial begin
    drive(6'b0, 6'b0, 1'b0);
    bus.stall_i = 1'b0;
    dec_tbl = '{
      '{6'b000000, 6'b100000, 1'b1, AluAdd,  1'b0},
      '{6'b000000, 6'b100111, 1'b1, AluNor,  1'b0},
      '{6'b001111, 6'b000000, 1'b1, AluLui,  1'b0},
      '{6'b111111, 6'b000000, 1'b1, AluNop,  1'b1},
      '{6'b000000, 6'b000100, 1'b1, AluSll,  1'b0},
      '{6'b000000, 6'b000111, 1'b1, AluSra,  1'b0},
      '{6'b000000, 6'b000110, 1'b1, AluSrl,  1'b0},
      '{6'b000100, 6'b010101, 1'b1, AluSub,  1'b0},
      '{6'b000101, 6'b000000, 1'b1, AluSub,  1'b0},
      '{6'b100011, 6'b000000, 1'b1, AluAdd,  1'b0},
      '{6'b101011, 6'b000000, 1'b1, AluAdd,  1'b0},
      '{6'b000011, 6'b000000, 1'b1, AluAdd,  1'b0},
      '{6'b001011, 6'b000000, 1'b1, AluSltu, 1'b0},
      '{6'b001001, 6'b000000, 1'b1, AluAddu, 1'b0},
      '{6'b001110, 6'b000000, 1'b1, AluXor,  1'b0},
      '{6'b000000, 6'b101010, 1'b1, AluSlt,  1'b0},
      '{6'b000000, 6'b100011, 1'b1, AluSubu, 1'b0},
      '{6'b000000, 6'b010000, 1'b1, AluNop,  1'b0},
      '{6'b000000, 6'b000001, 1'b1, AluNop,  1'b1},
      '{6'b000000, 6'b100000, 1'b0, AluNop,  1'b0}
    };

    // Reset state
    step(2);
    expect_reset(0, "reset");
    step(1);
    resetn = 1'b1;

    // Decode table: each word appears in E one cycle later
    foreach (dec_tbl[k]) begin
      drive(dec_tbl[k].op, dec_tbl[k].funct, dec_tbl[k].valid);
      expect_at(1, $sformatf("dec%0d_alu", k), SigAlu, 32'(dec_tbl[k].ctrl));
      expect_at(1, $sformatf("dec%0d_ri", k),  SigRi,  32'(dec_tbl[k].ri));
      step(1);
    end

    // Stall holds E, flush beats stall
    drive(6'b000000, 6'b100000, 1'b1);
    expect_at(1, "hold_pre", SigAlu, 32'(AluAdd));
    step(1);
    drive(6'b000000, 6'b100010, 1'b1);
    bus.stall_i = 1'b1;
    expect_at(1, "hold_alu", SigAlu, 32'(AluAdd));
    step(1);
    drive(6'b000000, 6'b100100, 1'b1);
    tb_flush = 1'b1;
    expect_at(1, "flush_alu", SigAlu, 32'(AluNop));
    step(1);
    tb_flush = 1'b0;
    bus.stall_i = 1'b0;
    drive(6'b000000, 6'b100101, 1'b1);
    expect_at(1, "after_flush_alu", SigAlu, 32'(AluOr));
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    step(2);

    // MULT: start, one RUN cycle, hilo_we two cycles after start
    drive(6'b000000, 6'b011000, 1'b1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    expect_at(0, "mult_start", SigStart, 1);
    expect_at(0, "mult_op",    SigOp,    0);
    expect_at(0, "mult_we0",   SigWe,    0);
    expect_at(1, "mult_busy1", SigBusy,  1);
    expect_at(1, "mult_st1",   SigStart, 0);
    expect_at(1, "mult_we1",   SigWe,    0);
    expect_at(2, "mult_we2",   SigWe,    1);
    expect_at(2, "mult_busy2", SigBusy,  0);
    expect_at(3, "mult_we3",   SigWe,    0);
    step(5);

    // MULT held in E across DONE: must not restart
    drive(6'b000000, 6'b011000, 1'b1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    bus.stall_i = 1'b1;
    expect_at(0, "mhold_start", SigStart, 1);
    for (int k = 1; k <= 5; k++) begin
      expect_at(k, $sformatf("mhold_st%0d", k), SigStart, 0);
      expect_at(k, $sformatf("mhold_we%0d", k), SigWe, (k == 2) ? 1 : 0);
      expect_at(k, $sformatf("mhold_bz%0d", k), SigBusy, (k == 1) ? 1 : 0);
    end
    step(5);
    bus.stall_i = 1'b0;
    step(2);

    // DIV with MFLO right behind: stall_o from start through last RUN cycle
    tb_hz = 1'b1;
    drive(6'b000000, 6'b011010, 1'b1);
    step(1);
    drive(6'b000000, 6'b010010, 1'b1);
    expect_at(0, "div_start", SigStart, 1);
    expect_at(0, "div_op",    SigOp,    2);
    for (int k = 0; k <= 32; k++) begin
      expect_at(k, $sformatf("div_stall%0d", k), SigStall, (k <= 31) ? 1 : 0);
      expect_at(k, $sformatf("div_we%0d", k),    SigWe,    (k == 32) ? 1 : 0);
      expect_at(k, $sformatf("div_bz%0d", k),    SigBusy,  (k >= 1 && k <= 31) ? 1 : 0);
    end
    step(33);
    drive(6'b0, 6'b0, 1'b0);
    tb_hz = 1'b0;
    expect_at(0, "mflo_e_stall", SigStall, 0);
    expect_at(0, "mflo_e_start", SigStart, 0);
    step(2);

    // DIVU held by stall for 5 cycles, then flushed mid-RUN
    drive(6'b000000, 6'b011011, 1'b1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    bus.stall_i = 1'b1;
    expect_at(0, "divu_start", SigStart, 1);
    expect_at(0, "divu_op",    SigOp,    3);
    for (int k = 1; k <= 33; k++) begin
      expect_at(k, $sformatf("divu_st%0d", k), SigStart, 0);
      expect_at(k, $sformatf("divu_we%0d", k), SigWe, (k == 32) ? 1 : 0);
      expect_at(k, $sformatf("divu_bz%0d", k), SigBusy, (k <= 31) ? 1 : 0);
    end
    step(5);
    bus.stall_i = 1'b0;
    step(5);
    tb_flush = 1'b1;
    step(1);
    tb_flush = 1'b0;
    step(25);

    // Back-to-back: MULTU enters E during DONE of a MULT
    drive(6'b000000, 6'b011000, 1'b1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    expect_at(0, "b2b_start0", SigStart, 1);
    step(1);
    drive(6'b000000, 6'b011001, 1'b1);
    expect_at(0, "b2b_stall_run", SigStall, 1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    expect_at(0, "b2b_we",     SigWe,    1);
    expect_at(0, "b2b_start1", SigStart, 1);
    expect_at(0, "b2b_op1",    SigOp,    1);
    expect_at(0, "b2b_stall_done", SigStall, 0);
    expect_at(1, "b2b_busy",   SigBusy,  1);
    expect_at(1, "b2b_we_n",   SigWe,    0);
    expect_at(2, "b2b_we2",    SigWe,    1);
    step(4);

    // Reset for one cycle mid-RUN: reset values next cycle, no hilo_we
    drive(6'b000000, 6'b011010, 1'b1);
    step(1);
    drive(6'b0, 6'b0, 1'b0);
    expect_at(0, "rst_start", SigStart, 1);
    expect_at(5, "rst_busy_pre", SigBusy, 1);
    step(5);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    expect_reset(0, "midrst");
    for (int k = 1; k <= 34; k++) begin
      expect_at(k, $sformatf("midrst_we%0d", k), SigWe,   0);
      expect_at(k, $sformatf("midrst_bz%0d", k), SigBusy, 0);
    end
    step(36);

    check("sb_drain", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aludec_mdu_ctrl.md
# aludec_mdu_ctrl

Parametrised decode-to-execute control block for the MIPS core. It does three things:
- Decodes op/funct into an ALU control word, covering the full integer ALU set.
- Registers that word, with a valid bit and multiply/divide class, into the D→E pipeline register, with stall and flush.
- Sequences the multi-cycle multiply/divide unit (MDU), raising a D-stage stall for HI/LO hazards.

It replaces the purely combinational ALU decoder between the controller and the datapath.

## Interface
Parameters:
- `CTRL_W`, 5: ALU control word width.
- `MUL_CYCLES`, 2: start-to-done cycles for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, 32: start-to-done cycles for DIV/DIVU; must be ≥1 and ≥`MUL_CYCLES`.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `op` in 6: D-stage opcode.
- `funct` in 6: D-stage funct.
- `valid_d` in 1: D-stage instruction valid.
- `stall_i` in 1: hazard-unit stall; holds the D→E register.
- `flush_i` in 1: loads a bubble into the D→E register.
- `aluctrl_e` out `CTRL_W`: registered ALU control for the E stage.
- `ri_e` out 1: registered reserved-instruction flag.
- `mdu_start` out 1: one-cycle start pulse to the MDU datapath.
- `mdu_op` out 2: operation code, valid with `mdu_start`; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `mdu_busy` out 1: high in RUN.
- `hilo_we` out 1: one-cycle HI/LO write strobe at completion.
- `stall_o` out 1: D-stage stall request for HI/LO hazards.

## Operation
Decode (combinational, D stage):
- R-type: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV.
- I/J-type: ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Mapping to control words:
  - Loads, stores, J, JAL → ADD.
  - BEQ, BNE → SUB.
  - Variable shifts → the matching shift control.
- MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO → NOP control word, and set the MDU class bits.
- Any other op/funct → NOP with ri=1.

D→E register:
- Reset or `flush_i` loads: `aluctrl_e`=NOP, `ri_e`=0, E-valid=0, E-MDU class cleared.
- Otherwise `stall_i` holds.
- Otherwise loads the D-stage decode, gated by `valid_d`. With `valid_d`=0 it loads a bubble.
- `flush_i` has priority over `stall_i`.

MDU sequencer, states IDLE, RUN, DONE:
- Start condition: E-valid, E-class is MULT/MULTU/DIV/DIVU, and state is IDLE or DONE. Under it:
  - `mdu_start`=1 and `mdu_op` is driven.
  - The counter is loaded with LAT−1, where LAT is `MUL_CYCLES` or `DIV_CYCLES`.
  - Next state is RUN, or DONE if LAT=1.
- RUN: the counter decrements each cycle; at 0 the next state is DONE.
- DONE: `hilo_we`=1 for exactly one cycle. Next state is IDLE, or RUN if a new start occurs in the same cycle.
- An E-stage op held by `stall_i` starts only once. It is tracked by a started flag that clears when the D→E register loads.
- `flush_i` and `stall_i` never abort a running operation; only reset does.
- Divide by zero is sequenced identically; the result value is the datapath's concern.

`stall_o` rule:
- Asserted when `valid_d` and the D op is any HI/LO-class instruction, and either:
  - state is RUN, or
  - a start condition holds this cycle.
- Not asserted in DONE: HI/LO is written at the DONE edge, before any D-stage MFHI/MFLO reaches E.

## Timing
- Reset values: `aluctrl_e`=NOP, `ri_e`=0, `mdu_start`=0, `mdu_op`=00, `mdu_busy`=0, `hilo_we`=0, `stall_o`=0, state=IDLE, counter=0.
- Decode-to-E latency: 1 cycle.
- `mdu_start`/`mdu_op` are combinational from the E register and state.
- `hilo_we` occurs exactly LAT cycles after the `mdu_start` cycle.
  - LAT=1: `hilo_we` is in the cycle after the start.
- Counter width: $clog2(`DIV_CYCLES`).
- Reset mid-RUN: returns to IDLE next edge; no `hilo_we`.
- `stall_o` depends on D inputs combinationally; no registered delay.

## Structure
- ALU control encodings belong in the shared defines header, alongside the existing op/funct defines:
  - control words: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, NOP;
  - MDU class codes;
  - state encodings.
- One sub-module, `mdu_seq`, holds the FSM, counter and started flag. Decode and the D→E register live in the top.

## Test plan
- op=000000 funct=100000, then funct=100111, then op=001111 → `aluctrl_e`=ADD, then NOR, then LUI, each one cycle later; op=111111 → NOP with `ri_e`=1.
- MULT in E with `MUL_CYCLES`=2 → `mdu_start`=1, `mdu_op`=00; `hilo_we` 2 cycles later; `mdu_busy` high 1 cycle.
- DIV with `DIV_CYCLES`=32 and MFLO immediately behind it → `stall_o` high from the start cycle through the last RUN cycle (32 cycles); MFLO enters E the cycle after `hilo_we`.
- DIVU in E with `stall_i`=1 for 5 cycles → exactly one `mdu_start`; then `flush_i` mid-RUN → sequence completes, `hilo_we` still fires.
- Back-to-back MULTU in E during DONE → `hilo_we` and `mdu_start` in the same cycle; state goes DONE→RUN.
- `resetn`=0 for one cycle mid-RUN → all outputs at reset values next cycle; no `hilo_we`.
